// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus arbiter: widths, unit indices
// and the layout of one CDB entry.
package cdb_pkg;

    localparam int CDB_NUM_UNITS = 4;
    localparam int CDB_ROB_SIZE  = 32;
    localparam int CDB_TAG_W     = $clog2(CDB_ROB_SIZE + 1);
    localparam int CDB_DATA_W    = 64;
    localparam int CMD_W         = 10;
    localparam int FLAGS_W       = 4;
    localparam int CDB_UNIT_W    = $clog2(CDB_NUM_UNITS);

    localparam logic [CDB_UNIT_W-1:0] UNIT_ALU = CDB_UNIT_W'(0);
    localparam logic [CDB_UNIT_W-1:0] UNIT_MUL = CDB_UNIT_W'(1);
    localparam logic [CDB_UNIT_W-1:0] UNIT_DIV = CDB_UNIT_W'(2);
    localparam logic [CDB_UNIT_W-1:0] UNIT_MEM = CDB_UNIT_W'(3);

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] val;
        logic [CMD_W-1:0]      commands;
        logic [FLAGS_W-1:0]    flags;
        logic [CDB_UNIT_W-1:0] unit;
    } cdb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requesters starting at the pointer, wrapping
// from N-1 back to 0, and returns a one-hot grant plus its encoded index.
// The pointer register itself lives in the parent; this block only proposes
// the next pointer value (one past the winner).
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic             enable,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grantIdx,
    output logic [IDX_W-1:0] nextPtr,
    output logic             anyGrant
);

    // First requester at or after the pointer wins, only when enabled.
    always_comb begin
        int k;
        k        = 0;
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        if (enable) begin
            for (int i = 0; i < N; i++) begin
                k = (int'(ptr) + i) % N;
                if (!anyGrant && req[k]) begin
                    anyGrant = 1'b1;
                    grant[k] = 1'b1;
                    grantIdx = IDX_W'(k);
                end
            end
        end
    end

    // Pointer moves to the unit just after the winner, wrapping at N.
    always_comb begin
        if (int'(grantIdx) == N - 1) begin
            nextPtr = '0;
        end else begin
            nextPtr = grantIdx + 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the single common data bus between the execute stages. A unit is
// released (canGo_o) on the edge its result is loaded into the CDB register;
// the register then presents the result to the ROB and reservation stations
// one cycle later. A held entry stays put while the ROB stalls, and a flush
// squashes it without granting anybody in that cycle.
// The entry layout comes from cdb_pkg, so the width parameters must stay at
// the package values.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_UNITS  = CDB_NUM_UNITS,
    parameter int ROBsize    = CDB_ROB_SIZE,
    parameter int ROBsizeLog = $clog2(ROBsize + 1),
    parameter int DATA_W     = CDB_DATA_W
) (
    input  logic                            clk_i,
    input  logic                            reset_ni,
    input  logic                            flush_i,
    input  logic                            cdbStall_i,
    input  logic [NUM_UNITS-1:0]            unitValid_i,
    input  logic [NUM_UNITS*ROBsizeLog-1:0] unitTag_i,
    input  logic [NUM_UNITS*DATA_W-1:0]     unitVal_i,
    input  logic [NUM_UNITS*CMD_W-1:0]      unitCommands_i,
    input  logic [NUM_UNITS*FLAGS_W-1:0]    unitFlags_i,
    output logic [NUM_UNITS-1:0]            canGo_o,
    output logic                            cdbValid_o,
    output logic [ROBsizeLog-1:0]           cdbTag_o,
    output logic [DATA_W-1:0]               cdbVal_o,
    output logic [CMD_W-1:0]                cdbCommands_o,
    output logic [FLAGS_W-1:0]              cdbFlags_o,
    output logic [$clog2(NUM_UNITS)-1:0]    cdbUnit_o
);

    localparam int UNIT_W = $clog2(NUM_UNITS);

    logic              accept;
    logic              anyGrant;
    logic [UNIT_W-1:0] grantIdx;
    logic [UNIT_W-1:0] nextPtr;
    logic [UNIT_W-1:0] rrPtr;
    logic              cdbValidQ;
    cdb_entry_t        cdbReg;
    cdb_entry_t        winner;

    // The register can take a new entry when it is empty or draining this
    // edge; flush blocks any grant, and canGo stays low while in reset.
    always_comb begin
        accept = reset_ni & ~flush_i & (~cdbValidQ | ~cdbStall_i);
    end

    rr_arbiter #(
        .N     (NUM_UNITS),
        .IDX_W (UNIT_W)
    ) uRrArbiter (
        .req      (unitValid_i),
        .enable   (accept),
        .ptr      (rrPtr),
        .grant    (canGo_o),
        .grantIdx (grantIdx),
        .nextPtr  (nextPtr),
        .anyGrant (anyGrant)
    );

    // Select the winning unit's payload slice.
    always_comb begin
        winner          = '0;
        winner.tag      = unitTag_i[grantIdx*ROBsizeLog +: ROBsizeLog];
        winner.val      = unitVal_i[grantIdx*DATA_W +: DATA_W];
        winner.commands = unitCommands_i[grantIdx*CMD_W +: CMD_W];
        winner.flags    = unitFlags_i[grantIdx*FLAGS_W +: FLAGS_W];
        winner.unit     = grantIdx;
    end

    // CDB register and round-robin pointer. Flush only clears valid; the
    // payload keeps its last value whenever nothing new is loaded.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cdbValidQ <= 1'b0;
            cdbReg    <= '0;
            rrPtr     <= '0;
        end else if (flush_i) begin
            cdbValidQ <= 1'b0;
        end else if (anyGrant) begin
            cdbValidQ <= 1'b1;
            cdbReg    <= winner;
            rrPtr     <= nextPtr;
        end else if (cdbValidQ && !cdbStall_i) begin
            cdbValidQ <= 1'b0;
        end
    end

    // Drive the CDB outputs straight from the register.
    always_comb begin
        cdbValid_o    = cdbValidQ;
        cdbTag_o      = cdbReg.tag;
        cdbVal_o      = cdbReg.val;
        cdbCommands_o = cdbReg.commands;
        cdbFlags_o    = cdbReg.flags;
        cdbUnit_o     = cdbReg.unit;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the CDB slot and RR pointer.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NU = 4;
    localparam int TW = 6;
    localparam int DW = 64;
    localparam int CW = 10;
    localparam int FW = 4;
    localparam int UW = 2;

    logic clk_i = 1'b0;
    logic reset_ni = 1'b0;
    logic flush_i = 1'b0;
    logic cdbStall_i = 1'b0;
    logic [NU-1:0] uv = '0;
    logic [TW-1:0] ut [NU];
    logic [DW-1:0] uval [NU];
    logic [CW-1:0] ucmd [NU];
    logic [FW-1:0] uflg [NU];

    logic [NU*TW-1:0] unitTag;
    logic [NU*DW-1:0] unitVal;
    logic [NU*CW-1:0] unitCmd;
    logic [NU*FW-1:0] unitFlg;

    logic [NU-1:0] canGo_o;
    logic          cdbValid_o;
    logic [TW-1:0] cdbTag_o;
    logic [DW-1:0] cdbVal_o;
    logic [CW-1:0] cdbCommands_o;
    logic [FW-1:0] cdbFlags_o;
    logic [UW-1:0] cdbUnit_o;

    cdb_arbiter dut (
        .clk_i          (clk_i),
        .reset_ni       (reset_ni),
        .flush_i        (flush_i),
        .cdbStall_i     (cdbStall_i),
        .unitValid_i    (uv),
        .unitTag_i      (unitTag),
        .unitVal_i      (unitVal),
        .unitCommands_i (unitCmd),
        .unitFlags_i    (unitFlg),
        .canGo_o        (canGo_o),
        .cdbValid_o     (cdbValid_o),
        .cdbTag_o       (cdbTag_o),
        .cdbVal_o       (cdbVal_o),
        .cdbCommands_o  (cdbCommands_o),
        .cdbFlags_o     (cdbFlags_o),
        .cdbUnit_o      (cdbUnit_o)
    );

    always #5 clk_i = ~clk_i;

    always_comb begin
        for (int k = 0; k < NU; k++) begin
            unitTag[k*TW +: TW] = ut[k];
            unitVal[k*DW +: DW] = uval[k];
            unitCmd[k*CW +: CW] = ucmd[k];
            unitFlg[k*FW +: FW] = uflg[k];
        end
    end

    // Reference model: one CDB slot plus the index of the unit with priority.
    bit            mValid;
    logic [TW-1:0] mTag;
    logic [DW-1:0] mVal;
    logic [CW-1:0] mCmd;
    logic [FW-1:0] mFlg;
    int            mUnit;
    int            mPtr;
    int            waitCnt [NU];
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 0; mTag = '0; mVal = '0; mCmd = '0; mFlg = '0;
        mUnit = 0; mPtr = 0;
        for (int k = 0; k < NU; k++) waitCnt[k] = 0;
    endtask

    task automatic setUnit(input int k);
        uv[k]   = 1'b1;
        ut[k]   = TW'($urandom_range(32, 0));
        uval[k] = {$urandom, $urandom};
        ucmd[k] = CW'($urandom);
        uflg[k] = FW'($urandom);
    endtask

    // Which unit should be released right now, by the arbitration rules.
    function automatic logic [NU-1:0] expGrant();
        logic [NU-1:0] g;
        g = '0;
        if (reset_ni && !flush_i && !(mValid && cdbStall_i)) begin
            for (int i = 0; i < NU; i++) begin
                if (g == '0 && uv[(mPtr + i) % NU]) g[(mPtr + i) % NU] = 1'b1;
            end
        end
        return g;
    endfunction

    task automatic checkAll(input string tag);
        #1;
        chk({tag, ":canGo"}, 64'(canGo_o), 64'(expGrant()));
        chk({tag, ":valid"}, 64'(cdbValid_o), 64'(mValid));
        chk({tag, ":tag"}, 64'(cdbTag_o), 64'(mTag));
        chk({tag, ":val"}, cdbVal_o, mVal);
        chk({tag, ":cmd"}, 64'(cdbCommands_o), 64'(mCmd));
        chk({tag, ":flags"}, 64'(cdbFlags_o), 64'(mFlg));
        chk({tag, ":unit"}, 64'(cdbUnit_o), 64'(mUnit));
    endtask

    // Advance one clock and update the model; a granted unit either drops
    // its request or immediately presents a fresh result.
    task automatic edgeStep(input bit refill);
        logic [NU-1:0] g;
        bit rst, fl, st;
        int k;
        g = expGrant(); rst = reset_ni; fl = flush_i; st = cdbStall_i;
        k = -1;
        for (int i = 0; i < NU; i++) if (g[i]) k = i;
        @(posedge clk_i);
        if (rst) begin
            if (fl) begin
                mValid = 0;
            end else if (k >= 0) begin
                mValid = 1; mTag = ut[k]; mVal = uval[k]; mCmd = ucmd[k];
                mFlg = uflg[k]; mUnit = k; mPtr = (k + 1) % NU;
                for (int j = 0; j < NU; j++) begin
                    if (j != k && uv[j]) begin
                        waitCnt[j]++;
                        chk("fairness", 64'(waitCnt[j] <= NU - 1), 64'd1);
                    end
                end
                waitCnt[k] = 0;
            end else if (mValid && !st) begin
                mValid = 0;
            end
        end
        #1;
        if (k >= 0) begin
            if (refill) setUnit(k);
            else uv[k] = 1'b0;
        end
    endtask

    task automatic doReset();
        reset_ni = 1'b0;
        modelReset();
        #2;
        reset_ni = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NU; k++) begin
            ut[k] = '0; uval[k] = '0; ucmd[k] = '0; uflg[k] = '0;
        end
        modelReset();

        // Reset holds canGo low even with every unit requesting.
        reset_ni = 1'b0;
        for (int k = 0; k < NU; k++) setUnit(k);
        checkAll("t1rst");
        chk("t1canGoRst", 64'(canGo_o), 64'h0);
        chk("t1validRst", 64'(cdbValid_o), 64'h0);
        edgeStep(0);
        reset_ni = 1'b1;
        checkAll("t1rel");
        chk("t1firstGrant", 64'(canGo_o), 64'h1);

        // Lone divider result.
        @(posedge clk_i); #1;
        reset_ni = 1'b0; modelReset(); uv = '0;
        #1;
        uv[2] = 1'b1; ut[2] = 6'd3; uval[2] = 64'd5; ucmd[2] = 10'h2a5; uflg[2] = 4'h9;
        reset_ni = 1'b1;
        checkAll("t2req");
        chk("t2canGo", 64'(canGo_o), 64'h4);
        edgeStep(0);
        checkAll("t2cdb");
        chk("t2valid", 64'(cdbValid_o), 64'h1);
        chk("t2tag", 64'(cdbTag_o), 64'd3);
        chk("t2val", cdbVal_o, 64'd5);
        chk("t2unit", 64'(cdbUnit_o), 64'(UNIT_DIV));
        chk("t2canGoOff", 64'(canGo_o), 64'h0);
        edgeStep(0);
        checkAll("t2drain");
        chk("t2drained", 64'(cdbValid_o), 64'h0);

        // Continuous requests from all units: strict rotation, no bubbles.
        doReset();
        for (int k = 0; k < NU; k++) setUnit(k);
        for (int i = 0; i < 6; i++) begin
            checkAll("t3");
            chk("t3order", 64'(canGo_o), 64'(1 << (i % NU)));
            edgeStep(1);
            chk("t3valid", 64'(cdbValid_o), 64'h1);
        end

        // ROB stall with unit 1's result held.
        cdbStall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkAll("t4stall");
            chk("t4canGo", 64'(canGo_o), 64'h0);
            chk("t4unit", 64'(cdbUnit_o), 64'(UNIT_MUL));
            edgeStep(1);
        end
        chk("t4heldValid", 64'(cdbValid_o), 64'h1);
        cdbStall_i = 1'b0;
        checkAll("t4resume");
        chk("t4resumeGrant", 64'(canGo_o), 64'h4);
        edgeStep(1);
        checkAll("t4b2b");
        chk("t4b2bValid", 64'(cdbValid_o), 64'h1);
        chk("t4b2bUnit", 64'(cdbUnit_o), 64'(UNIT_DIV));

        // Flush beats stall and squashes the held entry.
        uv[0] = 1'b0; uv[1] = 1'b0; uv[3] = 1'b0;
        setUnit(2);
        cdbStall_i = 1'b1; flush_i = 1'b1;
        checkAll("t5flush");
        chk("t5canGo", 64'(canGo_o), 64'h0);
        edgeStep(0);
        flush_i = 1'b0;
        checkAll("t5after");
        chk("t5squashed", 64'(cdbValid_o), 64'h0);
        chk("t5grant", 64'(canGo_o), 64'h4);
        edgeStep(0);
        cdbStall_i = 1'b0;
        checkAll("t5load");
        chk("t5loadUnit", 64'(cdbUnit_o), 64'(UNIT_DIV));

        // Asynchronous reset in the middle of a stall.
        for (int k = 0; k < NU; k++) setUnit(k);
        edgeStep(1);
        cdbStall_i = 1'b1;
        checkAll("t6pre");
        chk("t6preValid", 64'(cdbValid_o), 64'h1);
        reset_ni = 1'b0;
        modelReset();
        #1;
        chk("t6asyncValid", 64'(cdbValid_o), 64'h0);
        chk("t6asyncCanGo", 64'(canGo_o), 64'h0);
        checkAll("t6rst");
        edgeStep(1);
        reset_ni = 1'b1;
        cdbStall_i = 1'b0;
        checkAll("t6rel");
        chk("t6ptrZero", 64'(canGo_o), 64'(1 << UNIT_ALU));

        // Random traffic with stalls and occasional flushes.
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NU; k++) begin
                if (!uv[k] && $urandom_range(1, 0) == 1) setUnit(k);
            end
            cdbStall_i = ($urandom_range(3, 0) == 0);
            flush_i    = ($urandom_range(15, 0) == 0);
            checkAll("rnd");
            edgeStep(0);
        end
        flush_i = 1'b0;
        cdbStall_i = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
